// File: rtl/rd_req_scheduler.sv
// Round-robin scheduler sharing the CCI-P c0 read-request TX channel between the
// control-poll (ctrl) and run-data (run) read sources, with in-flight cap and drain.
module rd_req_scheduler #(
    parameter int ADDR_W          = 42,
    parameter int MDATA_W         = 16,
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_W           = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ctrl_req_valid,
    output logic               ctrl_req_ready,
    input  logic [ADDR_W-1:0]  ctrl_req_addr,
    input  logic [MDATA_W-1:0] ctrl_req_mdata,
    input  logic               run_req_valid,
    output logic               run_req_ready,
    input  logic [ADDR_W-1:0]  run_req_addr,
    input  logic [MDATA_W-1:0] run_req_mdata,
    input  logic               c0_tx_almost_full,
    output logic               rd_tx_valid,
    output logic [ADDR_W-1:0]  rd_tx_addr,
    output logic [MDATA_W-1:0] rd_tx_mdata,
    input  logic               rd_rsp_valid,
    input  logic               drain_req,
    output logic               drain_done,
    output logic [CNT_W-1:0]   outstanding,
    output logic               stall,
    output logic               err_underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_p0;
    logic               last_run_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic               drain_done_p0;
    logic               underflow_p0;
    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [MDATA_W-1:0] mdata_p1;

    logic can_issue;
    logic grant_ctrl;
    logic grant_run;
    logic accept;

    // A response arriving at zero is an error; the count clamps at zero rather than wrapping.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec)
            res = cnt + CNT_W'(1);
        else if (dec && !inc && (cnt != '0))
            res = cnt - CNT_W'(1);
        return res;
    endfunction

    // Stage 0: arbitration; readies stay low while reset is held.
    assign can_issue  = !reset && (state_p0 == ST_ISSUE) && !c0_tx_almost_full
                        && (cnt_p0 < MAX_CNT);
    assign grant_ctrl = can_issue && ctrl_req_valid && (!run_req_valid || last_run_p0);
    assign grant_run  = can_issue && run_req_valid && (!ctrl_req_valid || !last_run_p0);
    assign accept     = grant_ctrl || grant_run;

    assign ctrl_req_ready = grant_ctrl;
    assign run_req_ready  = grant_run;
    assign stall          = !can_issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0      <= ST_ISSUE;
            last_run_p0   <= 1'b1;
            cnt_p0        <= '0;
            drain_done_p0 <= 1'b0;
            underflow_p0  <= 1'b0;
            vld_p1        <= 1'b0;
            addr_p1       <= '0;
            mdata_p1      <= '0;
        end else begin
            // Stage 1: registered request towards c0 TX; payload holds when idle.
            vld_p1 <= accept;
            if (grant_ctrl) begin
                addr_p1     <= ctrl_req_addr;
                mdata_p1    <= ctrl_req_mdata;
                last_run_p0 <= 1'b0;
            end else if (grant_run) begin
                addr_p1     <= run_req_addr;
                mdata_p1    <= run_req_mdata;
                last_run_p0 <= 1'b1;
            end

            cnt_p0 <= cnt_next(cnt_p0, accept, rd_rsp_valid);
            if (rd_rsp_valid && (cnt_p0 == '0))
                underflow_p0 <= 1'b1;

            case (state_p0)
                ST_ISSUE: begin
                    if (drain_req)
                        state_p0 <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!drain_req)
                        state_p0 <= ST_ISSUE;
                    else if ((cnt_p0 == '0) && !vld_p1)
                        state_p0 <= ST_DONE;
                end
                ST_DONE: begin
                    if (!drain_req) begin
                        state_p0      <= ST_ISSUE;
                        drain_done_p0 <= 1'b0;
                    end else begin
                        drain_done_p0 <= 1'b1;
                    end
                end
                default: state_p0 <= ST_ISSUE;
            endcase
        end
    end

    assign rd_tx_valid   = vld_p1;
    assign rd_tx_addr    = addr_p1;
    assign rd_tx_mdata   = mdata_p1;
    assign outstanding   = cnt_p0;
    assign drain_done    = drain_done_p0;
    assign err_underflow = underflow_p0;

endmodule
